// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, function codes,
// ALU codes, mux select encodings and the controller state type.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // States that hold a memory request open and therefore run the wait counter.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. The controller side is the
// master; the datapath/memory side (or a testbench) uses the slave modport.
interface multicycle_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       MemReq;
  logic       MemWrite;
  logic       IorD;
  logic       IRWrite;
  logic       PCEn;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       InstrDone;
  logic       IllegalOp;
  logic       MemTimeout;
  logic [3:0] State;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output MemReq, MemWrite, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
           ALUControl, RegDst, MemtoReg, RegWrite, InstrDone, IllegalOp,
           MemTimeout, State
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  MemReq, MemWrite, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
           ALUControl, RegDst, MemtoReg, RegWrite, InstrDone, IllegalOp,
           MemTimeout, State
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU control decoder: maps the FSM's ALU operation class and the R-type
// function field to an ALU control code, flagging unsupported function codes.
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: illegal     = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared-memory multicycle MIPS datapath: sequences
// fetch/decode/execute, handles the memory-ready handshake and its timeout.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 -> PC when memory ready
// DECODE   | compute branch target, dispatch on Op
// MEMADR   | compute load/store address
// MEMRD    | read data memory at ALUOut
// MEMWB    | write loaded data to rt
// MEMWR    | write B to data memory at ALUOut
// EXEC     | R-type ALU operation
// ALUWB    | write ALU result to rd
// BRANCH   | compare A/B, conditionally load branch target
// ADDIEX   | A + SignImm
// ADDIWB   | write addi result to rt
// JUMP     | load jump target
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 8
) (
  input logic              CLK,
  input logic              RST,
  multicycle_ctrl_if.master bus
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              illegal_q, timeout_q;
  logic              set_illegal, set_timeout;

  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src, src_b;
  logic       src_a, reg_dst, mem_to_reg, reg_write, instr_done;
  alu_op_t    alu_op;
  logic [2:0] alu_control;
  logic       funct_illegal;

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (bus.Funct),
    .alu_control (alu_control),
    .illegal     (funct_illegal)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = PCSRC_ALU;
    src_a       = 1'b0;
    src_b       = SRCB_B;
    alu_op      = ALUOP_ADD;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    instr_done  = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        src_b   = SRCB_FOUR;
        if (bus.MemReady) begin
          ir_write  = 1'b1;
          pc_en     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        src_b = SRCB_IMM_SH;
        case (bus.Op)
          OP_LW, OP_SW:   state_nxt = S_MEMADR;
          OP_RTYPE:       state_nxt = S_EXEC;
          OP_ADDI:        state_nxt = S_ADDIEX;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J:           state_nxt = S_JUMP;
          default: begin
            set_illegal = 1'b1;
            state_nxt   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a     = 1'b1;
        src_b     = SRCB_IMM;
        state_nxt = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        // A ready arriving on the limit cycle still completes normally.
        if (bus.MemReady) begin
          state_nxt = S_MEMWB;
        end else if (wait_cnt == MAX_CNT) begin
          set_timeout = 1'b1;
          state_nxt   = S_FETCH;
        end
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.MemReady) begin
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end else if (wait_cnt == MAX_CNT) begin
          set_timeout = 1'b1;
          state_nxt   = S_FETCH;
        end
      end
      S_EXEC: begin
        src_a  = 1'b1;
        alu_op = ALUOP_FUNCT;
        if (funct_illegal) begin
          set_illegal = 1'b1;
          state_nxt   = S_FETCH;
        end else begin
          state_nxt = S_ALUWB;
        end
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_ADDIEX: begin
        src_a     = 1'b1;
        src_b     = SRCB_IMM;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        src_a      = 1'b1;
        alu_op     = ALUOP_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_en      = (bus.Op == OP_BNE) ? ~bus.Zero : bus.Zero;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Counter restarts whenever a request state is freshly entered.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if ((state_nxt != state) && is_mem_state(state_nxt)) begin
      wait_cnt_nxt = '0;
    end else if (is_mem_state(state) && !bus.MemReady && (wait_cnt != '1)) begin
      wait_cnt_nxt = wait_cnt + WAIT_W'(1);
    end
  end

  assign bus.MemReq     = RST & mem_req;
  assign bus.MemWrite   = RST & mem_write;
  assign bus.IorD       = RST & iord;
  assign bus.IRWrite    = RST & ir_write;
  assign bus.PCEn       = RST & pc_en;
  assign bus.PCSrc      = RST ? pc_src : 2'b00;
  assign bus.ALUSrcA    = RST & src_a;
  assign bus.ALUSrcB    = RST ? src_b : 2'b00;
  assign bus.ALUControl = RST ? alu_control : 3'b000;
  assign bus.RegDst     = RST & reg_dst;
  assign bus.MemtoReg   = RST & mem_to_reg;
  assign bus.RegWrite   = RST & reg_write;
  assign bus.InstrDone  = RST & instr_done;
  assign bus.IllegalOp  = illegal_q;
  assign bus.MemTimeout = timeout_q;
  assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expectations from a
// behavioural model, compared by a monitor that slices the run at each FETCH entry.
module tb_multicycle_ctrl;

  localparam int MAXW = 15;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MAX_WAIT(MAXW), .WAIT_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int cycles;
    int reg_writes;
    int dones;
    int pc_ens;
    int mem_writes;
    int pcsrc_last;
    int reg_dst;
    int mem_to_reg;
    int alu;
    int conflicts;
    int illegal;
    int timeout;
    bit alu_chk;
  } rec_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         z;
    int         fd;
    int         md;
    bit         rst;
  } stim_t;

  rec_t  exp_q[$];
  stim_t stims[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    m_illegal = 0;
  bit    m_timeout = 0;

  logic [5:0] legal_fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [5:0] bad_ops   [4] = '{6'b111111, 6'b000001, 6'b100000, 6'b110000};

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Expected outcome of one instruction from fetch start to the next fetch.
  function automatic rec_t model(logic [5:0] op, logic [5:0] fn, bit z, int fd, int md);
    rec_t r = '{default: 0};
    bit ok_fn = 1'b1;
    int code = 0;
    case (fn)
      6'b100000: code = 2;
      6'b100010: code = 6;
      6'b100100: code = 0;
      6'b100101: code = 1;
      6'b101010: code = 7;
      default:   ok_fn = 1'b0;
    endcase
    r.cycles = fd + 1;
    r.pc_ens = 1;
    case (op)
      6'b100011, 6'b101011: begin
        r.cycles += 2;
        if (md <= MAXW) begin
          r.dones = 1;
          if (op == 6'b100011) begin
            r.cycles += md + 2;
            r.reg_writes = 1;
            r.mem_to_reg = 1;
          end else begin
            r.cycles += md + 1;
            r.mem_writes = md + 1;
          end
        end else begin
          r.cycles += MAXW + 1;
          if (op == 6'b101011) r.mem_writes = MAXW + 1;
          m_timeout = 1'b1;
        end
      end
      6'b000000: begin
        r.cycles += 2;
        if (ok_fn) begin
          r.cycles += 1;
          r.reg_writes = 1;
          r.dones = 1;
          r.reg_dst = 1;
          r.alu_chk = 1'b1;
          r.alu = code;
        end else begin
          m_illegal = 1'b1;
        end
      end
      6'b001000: begin
        r.cycles += 3;
        r.reg_writes = 1;
        r.dones = 1;
      end
      6'b000100, 6'b000101: begin
        r.cycles += 2;
        r.dones = 1;
        if ((op == 6'b000100) ? z : !z) begin
          r.pc_ens += 1;
          r.pcsrc_last = 1;
        end
      end
      6'b000010: begin
        r.cycles += 2;
        r.dones = 1;
        r.pc_ens += 1;
        r.pcsrc_last = 2;
      end
      default: begin
        r.cycles += 1;
        m_illegal = 1'b1;
      end
    endcase
    r.illegal = m_illegal;
    r.timeout = m_timeout;
    return r;
  endfunction

  // Memory model: answers each request after a per-request number of wait cycles.
  int fetch_delay = 0;
  int data_delay  = 0;
  bit mem_force   = 1'b1;
  int req_cnt     = 0;
  bit prev_req    = 1'b0;
  bit prev_iord   = 1'b0;

  initial bus.MemReady = 1'b1;

  always begin
    @(posedge CLK);
    #2;
    if (mem_force) begin
      bus.MemReady = 1'b1;
    end else if (bus.MemReq) begin
      if (!prev_req || (prev_iord != bus.IorD)) req_cnt = 0;
      bus.MemReady = (req_cnt == (bus.IorD ? data_delay : fetch_delay));
      req_cnt++;
    end else begin
      bus.MemReady = 1'($urandom_range(0, 1));
    end
    prev_req  = bus.MemReq;
    prev_iord = bus.IorD;
  end

  // Monitor: accumulate one record per instruction, compare at next FETCH entry.
  rec_t acc = '{default: 0};
  int   prev_state = 15;
  bit   open = 1'b0;

  task automatic finalize(rec_t a);
    rec_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_instruction", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("cycles",       a.cycles,     e.cycles);
    check("reg_writes",   a.reg_writes, e.reg_writes);
    check("instr_done",   a.dones,      e.dones);
    check("pc_en_count",  a.pc_ens,     e.pc_ens);
    check("mem_write",    a.mem_writes, e.mem_writes);
    check("pcsrc_at_pcen", a.pcsrc_last, e.pcsrc_last);
    check("reg_dst",      a.reg_dst,    e.reg_dst);
    check("mem_to_reg",   a.mem_to_reg, e.mem_to_reg);
    if (e.alu_chk) check("alu_control", a.alu, e.alu);
    check("strobe_conflict", a.conflicts, 0);
    check("illegal_op",   int'(bus.IllegalOp),  e.illegal);
    check("mem_timeout",  int'(bus.MemTimeout), e.timeout);
  endtask

  always @(negedge CLK) begin
    if (bus.State == 4'd0 && prev_state != 0) begin
      if (open) finalize(acc);
      open = RST;
      acc  = '{default: 0};
    end
    if (!RST) begin
      open = 1'b0;
      prev_state = 15;
    end else begin
      if (open) begin
        acc.cycles++;
        acc.reg_writes += int'(bus.RegWrite);
        acc.dones      += int'(bus.InstrDone);
        acc.pc_ens     += int'(bus.PCEn);
        acc.mem_writes += int'(bus.MemWrite);
        if (bus.PCEn) acc.pcsrc_last = int'(bus.PCSrc);
        if (bus.RegWrite) begin
          acc.reg_dst    = int'(bus.RegDst);
          acc.mem_to_reg = int'(bus.MemtoReg);
        end
        if (bus.State == 4'd6) acc.alu = int'(bus.ALUControl);
        if (bus.RegWrite && (bus.PCEn || bus.IRWrite)) acc.conflicts++;
      end
      prev_state = int'(bus.State);
    end
  end

  // Driver
  task automatic issue(stim_t s);
    bus.Op = s.op;
    bus.Funct = s.fn;
    bus.Zero = s.z;
    fetch_delay = s.fd;
    data_delay = s.md;
    exp_q.push_back(model(s.op, s.fn, s.z, s.fd, s.md));
    RST = 1'b1;
    mem_force = 1'b0;
  endtask

  task automatic wait_boundary();
    bit left = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge CLK);
      #1;
      if (bus.State != 4'd0) left = 1'b1;
      else if (left) return;
    end
    $display("FAIL instruction_end_timeout: state stuck at %0d", bus.State);
    $fatal(1, "instruction did not complete");
  endtask

  function automatic stim_t mk(logic [5:0] op, logic [5:0] fn, bit z, int fd, int md, bit r);
    stim_t s;
    s.op = op; s.fn = fn; s.z = z; s.fd = fd; s.md = md; s.rst = r;
    return s;
  endfunction

  initial begin
    RST = 1'b0;
    bus.Op = 6'd0;
    bus.Funct = 6'd0;
    bus.Zero = 1'b0;

    stims.push_back(mk(6'b100011, 6'd0,      0, 0, 0,  0)); // lw, ready at once
    stims.push_back(mk(6'b000100, 6'd0,      1, 0, 0,  0)); // beq taken
    stims.push_back(mk(6'b000101, 6'd0,      1, 1, 0,  0)); // bne not taken
    stims.push_back(mk(6'b101011, 6'd0,      0, 0, 3,  0)); // sw, 3 wait cycles
    stims.push_back(mk(6'b100011, 6'd0,      0, 0, 99, 0)); // lw, never ready
    stims.push_back(mk(6'b100011, 6'd0,      0, 2, 15, 1)); // ready on limit cycle
    stims.push_back(mk(6'b101011, 6'd0,      0, 0, 16, 0)); // sw one past limit
    stims.push_back(mk(6'b000000, 6'b100010, 0, 0, 0,  1)); // sub
    stims.push_back(mk(6'b111111, 6'd0,      0, 0, 0,  0)); // illegal op
    stims.push_back(mk(6'b000000, 6'b000000, 0, 0, 0,  1)); // illegal funct
    stims.push_back(mk(6'b001000, 6'd0,      0, 0, 0,  1)); // addi
    stims.push_back(mk(6'b000010, 6'd0,      0, 5, 0,  0)); // j, slow fetch
    for (int i = 0; i < 60; i++) begin
      stim_t s;
      int k = $urandom_range(0, 8);
      case (k)
        0: s.op = 6'b100011;
        1: s.op = 6'b101011;
        2, 3: s.op = 6'b000000;
        4: s.op = 6'b001000;
        5: s.op = 6'b000100;
        6: s.op = 6'b000101;
        7: s.op = 6'b000010;
        default: s.op = bad_ops[$urandom_range(0, 3)];
      endcase
      s.fn  = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 4)];
      s.z   = 1'($urandom_range(0, 1));
      s.fd  = $urandom_range(0, 3);
      s.md  = ($urandom_range(0, 4) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
      s.rst = (i % 12 == 11);
      stims.push_back(s);
    end

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_strobes", int'({bus.MemReq, bus.MemWrite, bus.IRWrite, bus.PCEn,
                                 bus.RegWrite, bus.InstrDone}), 0);
    check("reset_selects", int'({bus.PCSrc, bus.ALUSrcB, bus.ALUControl, bus.IorD,
                                 bus.ALUSrcA, bus.RegDst, bus.MemtoReg}), 0);
    check("reset_state", int'(bus.State), 0);
    check("reset_flags", int'({bus.IllegalOp, bus.MemTimeout}), 0);

    @(posedge CLK);
    #1;
    issue(stims[0]);
    @(negedge CLK);
    check("release_memreq", int'(bus.MemReq), 1);

    for (int i = 1; i < stims.size(); i++) begin
      wait_boundary();
      if (stims[i].rst) begin
        RST = 1'b0;
        mem_force = 1'b1;
        m_illegal = 1'b0;
        m_timeout = 1'b0;
        repeat (2) begin
          @(posedge CLK);
          #1;
        end
      end
      issue(stims[i]);
    end

    wait_boundary();
    issue(mk(6'b111111, 6'd0, 0, 0, 0, 0));
    wait_boundary();

    // Reset in the middle of an R-type: no writeback, stickies cleared.
    bus.Op = 6'b000000;
    bus.Funct = 6'b100000;
    fetch_delay = 0;
    for (int n = 0; n < 50 && bus.State != 4'd6; n++) begin
      @(posedge CLK);
      #1;
    end
    check("reach_exec", int'(bus.State), 6);
    check("illegal_before_reset", int'(bus.IllegalOp), 1);
    RST = 1'b0;
    mem_force = 1'b1;
    @(negedge CLK);
    check("rst_exec_strobes", int'({bus.RegWrite, bus.InstrDone, bus.PCEn}), 0);
    @(posedge CLK);
    #1;
    check("rst_exec_state", int'(bus.State), 0);
    check("rst_clears_illegal", int'(bus.IllegalOp), 0);
    repeat (2) @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
